// File: rtl/mem_port_arbiter_if.sv
// Fetch/load/store request ports and unified memory command bus for mem_port_arbiter.
// slave = arbiter side, master = core plus memory model side.
interface mem_port_arbiter_if #(
  parameter int W = 32
);
  logic           if_req;
  logic [W-1:0]   if_addr;
  logic           if_gnt;
  logic           if_rvalid;
  logic [W-1:0]   if_rdata;

  logic           ld_req;
  logic [W-1:0]   ld_addr;
  logic           ld_gnt;
  logic           ld_rvalid;
  logic [W-1:0]   ld_rdata;

  logic           st_req;
  logic [W-1:0]   st_addr;
  logic [W-1:0]   st_data;
  logic [W/8-1:0] st_be;
  logic           st_gnt;

  logic           m_en;
  logic           m_we;
  logic [W-1:0]   m_addr;
  logic [W-1:0]   m_wdata;
  logic [W/8-1:0] m_be;
  logic [W-1:0]   m_rdata;

  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_data, st_be, m_rdata,
    output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, st_gnt,
           m_en, m_we, m_addr, m_wdata, m_be
  );

  modport master (
    output if_req, if_addr, ld_req, ld_addr, st_req, st_addr, st_data, st_be, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, st_gnt,
           m_en, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch/load/store: store > load > fetch with a fetch
// starvation guard; reads are tracked through MEM_LAT and returned to their issuer.
module mem_port_arbiter #(
  parameter int W          = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [LW-1:0] LAT  = LW'(MEM_LAT);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIM);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t         state_q;
  logic [LW-1:0]  lat_q;
  logic [SW-1:0]  starve_q, starve_d;
  logic           owner_ld_q;
  logic           if_rvalid_q, ld_rvalid_q;
  logic [W-1:0]   if_rdata_q, ld_rdata_q;
  logic           gnt_if, gnt_ld, gnt_st;

  always_comb begin
    gnt_if = 1'b0;
    gnt_ld = 1'b0;
    gnt_st = 1'b0;
    if (state_q == IDLE) begin
      if (starve_q == SLIM && bus.if_req) gnt_if = 1'b1;
      else if (bus.st_req)                gnt_st = 1'b1;
      else if (bus.ld_req)                gnt_ld = 1'b1;
      else if (bus.if_req)                gnt_if = 1'b1;
    end
  end

  // Command bus is fully zeroed whenever nothing is granted.
  always_comb begin
    bus.m_en    = gnt_if | gnt_ld | gnt_st;
    bus.m_we    = gnt_st;
    bus.m_addr  = gnt_st ? bus.st_addr : gnt_ld ? bus.ld_addr : gnt_if ? bus.if_addr : '0;
    bus.m_wdata = gnt_st ? bus.st_data : '0;
    bus.m_be    = gnt_st ? bus.st_be : (gnt_ld | gnt_if) ? '1 : '0;
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || gnt_if)                     starve_d = '0;
    else if ((gnt_ld || gnt_st) && starve_q != SLIM) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      owner_ld_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ld_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        IDLE: if (gnt_if || gnt_ld) begin
          state_q    <= RD_WAIT;
          lat_q      <= LAT;
          owner_ld_q <= gnt_ld;
        end
        RD_WAIT: begin
          lat_q <= lat_q - LW'(1);
          // lat_q==1 is the cycle m_rdata is valid; rvalid lands with the return to IDLE.
          if (lat_q == LW'(1)) begin
            state_q <= IDLE;
            if (owner_ld_q) begin
              ld_rdata_q  <= bus.m_rdata;
              ld_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= bus.m_rdata;
              if_rvalid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.ld_gnt    = gnt_ld;
  assign bus.st_gnt    = gnt_st;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ld_rvalid = ld_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ld_rdata  = ld_rdata_q;
endmodule
